// File: rtl/wb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module  : wb_trace_capture
// Brief   : Arms on a pulse, records qualified register writebacks into a
//           first-word-fall-through FIFO until stop_pc retires, then drains.
// Revision: 1.0 - initial release
// ============================================================================
module wb_trace_capture #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [31:0]      stop_pc,
    input  logic [31:0]      prog_count,
    input  logic [4:0]       write_reg_addr,
    input  logic [31:0]      write_reg_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [4:0]       out_reg_addr,
    output logic [31:0]      out_reg_data,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             done
);

    localparam int               c_AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_FULL       = CNT_W'(DEPTH);
    localparam logic [1:0]       c_ST_IDLE    = 2'd0;
    localparam logic [1:0]       c_ST_CAPTURE = 2'd1;
    localparam logic [1:0]       c_ST_DRAIN   = 2'd2;
    localparam logic [1:0]       c_ST_DONE    = 2'd3;

    logic [1:0]       r_state;
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_done;
    logic [31:0]      r_last_pc;
    logic             r_last_vld;
    logic [68:0]      r_mem [DEPTH];

    logic             w_nonempty;
    logic             w_pop;
    logic             w_qual;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [68:0]      w_head;

    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty & out_ready;
    assign w_full     = (r_count == c_FULL);
    // A repeated PC is the same instruction stalled in writeback, not a new one.
    assign w_qual     = (r_state == c_ST_CAPTURE) && (write_reg_addr != 5'd0) &&
                        (!r_last_vld || (prog_count != r_last_pc));
    assign w_push     = w_qual && (!w_full || w_pop);
    assign w_drop     = w_qual && w_full && !w_pop;
    assign w_head     = r_mem[r_rptr];

    assign out_valid    = w_nonempty;
    assign out_pc       = w_nonempty ? w_head[68:37] : 32'd0;
    assign out_reg_addr = w_nonempty ? w_head[36:32] : 5'd0;
    assign out_reg_data = w_nonempty ? w_head[31:0]  : 32'd0;
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign done         = r_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {prog_count, write_reg_addr, write_reg_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= c_ST_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_last_pc  <= '0;
            r_last_vld <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (arm) begin
                        r_state    <= c_ST_CAPTURE;
                        r_overflow <= 1'b0;
                        r_last_vld <= 1'b0;
                        r_done     <= 1'b0;
                    end
                end
                c_ST_CAPTURE: begin
                    r_last_pc  <= prog_count;
                    r_last_vld <= 1'b1;
                    if (prog_count == stop_pc) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    // No pushes here, so count only falls; leave once it hits zero.
                    if (!w_nonempty || ((r_count == CNT_W'(1)) && w_pop)) begin
                        r_state <= c_ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_trace_capture
// Brief   : Self-checking bench for wb_trace_capture, directed scenarios plus
//           randomized traffic against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wb_trace_capture;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic [31:0]      stop_pc;
    logic [31:0]      prog_count;
    logic [4:0]       write_reg_addr;
    logic [31:0]      write_reg_data;
    logic             out_ready;
    logic             out_valid;
    logic [31:0]      out_pc;
    logic [4:0]       out_reg_addr;
    logic [31:0]      out_reg_data;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_trace_capture #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .arm            (arm),
        .stop_pc        (stop_pc),
        .prog_count     (prog_count),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_reg_addr   (out_reg_addr),
        .out_reg_data   (out_reg_data),
        .count          (count),
        .overflow       (overflow),
        .done           (done)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    // Reference model: a queue of captured entries plus the capture mode.
    entry_t      q[$];
    int          m_mode;      // 0 idle, 1 capturing, 2 draining, 3 finished
    logic [31:0] m_last_pc;
    bit          m_last_seen;
    bit          m_ovf;

    task automatic model_reset();
        q.delete();
        m_mode      = 0;
        m_last_pc   = 32'd0;
        m_last_seen = 1'b0;
        m_ovf       = 1'b0;
    endtask

    task automatic model_edge();
        bit     do_pop;
        bit     want;
        bit     take;
        entry_t tmp;
        do_pop = (q.size() != 0) && out_ready;
        want   = (m_mode == 1) && (write_reg_addr != 5'd0) &&
                 (!m_last_seen || (prog_count != m_last_pc));
        take   = want && ((q.size() < DEPTH) || do_pop);
        if (do_pop) tmp = q.pop_front();
        if (take) q.push_back({prog_count, write_reg_addr, write_reg_data});
        if (want && !take) m_ovf = 1'b1;
        if (m_mode == 0 || m_mode == 3) begin
            if (arm) begin
                m_mode      = 1;
                m_ovf       = 1'b0;
                m_last_seen = 1'b0;
            end
        end else if (m_mode == 1) begin
            m_last_pc   = prog_count;
            m_last_seen = 1'b1;
            if (prog_count == stop_pc) m_mode = 2;
        end else if (q.size() == 0) begin
            m_mode = 3;
        end
    endtask

    task automatic step(input bit a, input logic [31:0] pc, input logic [4:0] ad,
                        input logic [31:0] d, input bit rdy);
        arm            = a;
        prog_count     = pc;
        write_reg_addr = ad;
        write_reg_data = d;
        out_ready      = rdy;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arm            = 1'b0;
        out_ready      = 1'b0;
        write_reg_addr = 5'd0;
        rst            = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || overflow !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: count=%0d valid=%b ovf=%b done=%b, want 0 0 0 0",
                     count, out_valid, overflow, done);
        end
        checks++;
        if (out_pc !== 32'd0 || out_reg_addr !== 5'd0 || out_reg_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_fields: pc=%h addr=%h data=%h, want zeros",
                     out_pc, out_reg_addr, out_reg_data);
        end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        stop_pc = 32'd8;
        step(1, 32'd0, 5'd0, 32'd0, 1);
        step(0, 32'd0, 5'd2, 32'd100, 1);
        checks++;
        if (count !== 4'd1 || out_pc !== 32'd0 || out_reg_addr !== 5'd2 || out_reg_data !== 32'd100) begin
            errors++;
            $display("FAIL basic_e0: count=%0d pc=%0d addr=%0d data=%0d, want 1 0 2 100",
                     count, out_pc, out_reg_addr, out_reg_data);
        end
        step(0, 32'd4, 5'd4, 32'd535, 1);
        checks++;
        if (count !== 4'd1 || out_pc !== 32'd4 || out_reg_data !== 32'd535) begin
            errors++;
            $display("FAIL basic_e1: count=%0d pc=%0d data=%0d, want 1 4 535", count, out_pc, out_reg_data);
        end
        step(0, 32'd8, 5'd4, 32'd461, 1);
        checks++;
        if (count !== 4'd1 || out_pc !== 32'd8 || out_reg_data !== 32'd461 || done !== 1'b0) begin
            errors++;
            $display("FAIL basic_e2: count=%0d pc=%0d data=%0d done=%b, want 1 8 461 0",
                     count, out_pc, out_reg_data, done);
        end
        step(0, 32'd12, 5'd0, 32'd0, 1);
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: valid=%b done=%b ovf=%b, want 0 1 0", out_valid, done, overflow);
        end
    endtask

    task automatic test_dedup();
        do_reset();
        stop_pc = 32'd100;
        step(1, 32'd0, 5'd0, 32'd0, 0);
        repeat (3) step(0, 32'd20, 5'd4, 32'd535, 0);
        step(0, 32'd24, 5'd0, 32'd7, 0);
        step(0, 32'd28, 5'd0, 32'd9, 0);
        checks++;
        if (count !== 4'd1 || out_pc !== 32'd20 || out_reg_data !== 32'd535) begin
            errors++;
            $display("FAIL dedup_one: count=%0d pc=%0d data=%0d, want 1 20 535", count, out_pc, out_reg_data);
        end
        step(0, 32'd20, 5'd5, 32'd1, 0);
        checks++;
        if (count !== 4'd2) begin
            errors++;
            $display("FAIL dedup_revisit: count=%0d, want 2", count);
        end
        step(0, 32'd100, 5'd0, 32'd0, 1);
        step(0, 32'd104, 5'd0, 32'd0, 1);
        checks++;
        if (done !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL dedup_done: done=%b count=%0d, want 1 0", done, count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        stop_pc = 32'd1000;
        step(1, 32'd0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 10; i++) step(0, 32'd64 + 32'(4 * i), 5'(1 + i), 32'd1000 + 32'(i), 0);
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1 || out_pc !== 32'd64) begin
            errors++;
            $display("FAIL ovf_fill: count=%0d ovf=%b pc=%0d, want 8 1 64", count, overflow, out_pc);
        end
        step(0, 32'd1000, 5'd0, 32'd0, 0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (out_pc !== 32'd64 + 32'(4 * i) || out_reg_data !== 32'd1000 + 32'(i)) begin
                errors++;
                $display("FAIL ovf_order[%0d]: pc=%0d data=%0d, want %0d %0d",
                         i, out_pc, out_reg_data, 64 + 4 * i, 1000 + i);
            end
            step(0, 32'd0, 5'd0, 32'd0, 1);
        end
        checks++;
        if (done !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: done=%b ovf=%b, want 1 1", done, overflow);
        end
        step(1, 32'd0, 5'd0, 32'd0, 0);
        checks++;
        if (done !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rearm_done: done=%b ovf=%b, want 0 0", done, overflow);
        end
    endtask

    task automatic test_full_pop();
        bit finished;
        do_reset();
        stop_pc = 32'd1000;
        step(1, 32'd0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 8; i++) step(0, 32'd200 + 32'(4 * i), 5'd3, 32'(i), 0);
        step(0, 32'd300, 5'd3, 32'd77, 1);
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0 || out_pc !== 32'd204) begin
            errors++;
            $display("FAIL full_pop: count=%0d ovf=%b pc=%0d, want 8 0 204", count, overflow, out_pc);
        end
        step(0, 32'd304, 5'd3, 32'd78, 0);
        checks++;
        if (count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_drop: count=%0d ovf=%b, want 8 1", count, overflow);
        end
        step(0, 32'd1000, 5'd0, 32'd0, 1);
        finished = 1'b0;
        for (int i = 0; i < 20 && !finished; i++) begin
            step(0, 32'd0, 5'd0, 32'd0, 1);
            finished = done;
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL full_drain_timeout: done=%b count=%0d, want done 1", done, count);
        end
    endtask

    task automatic test_arm_in_drain();
        do_reset();
        stop_pc = 32'd40;
        step(1, 32'd0, 5'd0, 32'd0, 0);
        step(0, 32'd32, 5'd6, 32'd1, 0);
        step(0, 32'd36, 5'd6, 32'd2, 0);
        step(0, 32'd40, 5'd6, 32'd3, 0);
        step(1, 32'd44, 5'd7, 32'd4, 0);
        step(0, 32'd48, 5'd7, 32'd5, 0);
        checks++;
        if (count !== 4'd3 || done !== 1'b0) begin
            errors++;
            $display("FAIL drain_arm_ignored: count=%0d done=%b, want 3 0", count, done);
        end
        repeat (3) step(0, 32'd0, 5'd0, 32'd0, 1);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: done=%b valid=%b, want 1 0", done, out_valid);
        end
        step(1, 32'd0, 5'd0, 32'd0, 0);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_rearm: done=%b, want 0", done);
        end
        step(0, 32'd60, 5'd2, 32'd9, 0);
        checks++;
        if (count !== 4'd1 || out_pc !== 32'd60) begin
            errors++;
            $display("FAIL rearm_capture: count=%0d pc=%0d, want 1 60", count, out_pc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        stop_pc = 32'd1000;
        step(1, 32'd0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 3; i++) step(0, 32'd400 + 32'(4 * i), 5'd9, 32'(i), 0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || out_pc !== 32'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d valid=%b pc=%0d done=%b, want 0 0 0 0",
                     count, out_valid, out_pc, done);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(0, 32'd500, 5'd9, 32'd1, 0);
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("FAIL async_idle: count=%0d, want 0", count);
        end
        step(1, 32'd0, 5'd0, 32'd0, 0);
        step(0, 32'd504, 5'd9, 32'd2, 0);
        checks++;
        if (count !== 4'd1 || out_pc !== 32'd504 || out_reg_data !== 32'd2) begin
            errors++;
            $display("FAIL async_restart: count=%0d pc=%0d data=%0d, want 1 504 2", count, out_pc, out_reg_data);
        end
    endtask

    task automatic test_random();
        entry_t exp_head;
        do_reset();
        stop_pc = 32'd60;
        for (int n = 0; n < 3000; n++) begin
            step(($urandom % 8) == 0,
                 32'($urandom_range(0, 15) * 4),
                 (($urandom % 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom,
                 ($urandom % 3) == 0);
            exp_head = (q.size() != 0) ? q[0] : '0;
            checks++;
            if (count !== CNT_W'(q.size()) || out_valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_count[%0d]: count=%0d valid=%b, want %0d %b",
                         n, count, out_valid, q.size(), q.size() != 0);
            end
            checks++;
            if (out_pc !== exp_head.pc || out_reg_addr !== exp_head.addr || out_reg_data !== exp_head.data) begin
                errors++;
                $display("FAIL rand_head[%0d]: pc=%h addr=%h data=%h, want %h %h %h",
                         n, out_pc, out_reg_addr, out_reg_data, exp_head.pc, exp_head.addr, exp_head.data);
            end
            checks++;
            if (overflow !== m_ovf || done !== (m_mode == 3)) begin
                errors++;
                $display("FAIL rand_flags[%0d]: ovf=%b done=%b, want %b %b",
                         n, overflow, done, m_ovf, m_mode == 3);
            end
        end
    endtask

    initial begin
        rst            = 1'b1;
        arm            = 1'b0;
        stop_pc        = 32'd0;
        prog_count     = 32'd0;
        write_reg_addr = 5'd0;
        write_reg_data = 32'd0;
        out_ready      = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_basic();
        test_dedup();
        test_overflow();
        test_full_pop();
        test_arm_in_drain();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_trace_capture.md
WB_TRACE_CAPTURE -- requirements
Module: wb_trace_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 8, trace FIFO entries (power of two, >= 2).
REQ-002 SHALL have parameter CNT_W, default 4, width of count output (log2(DEPTH)+1).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port arm  input  1  single-cycle start-capture pulse.
REQ-006 SHALL have port stop_pc  input  32  PC of last instruction to capture.
REQ-007 SHALL have port prog_count  input  32  processor PC of current instruction.
REQ-008 SHALL have port write_reg_addr  input  5  processor writeback register address.
REQ-009 SHALL have port write_reg_data  input  32  processor writeback data.
REQ-010 SHALL have port out_ready  input  1  consumer accepts head entry.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have ports out_pc (32), out_reg_addr (5), out_reg_data (32), outputs, head entry fields.
REQ-013 SHALL have port count  output  CNT_W  entries currently held.
REQ-014 SHALL have port overflow  output  1  sticky, set when an entry was dropped.
REQ-015 SHALL have port done  output  1  capture finished and FIFO drained.

Function
REQ-016 SHALL implement FSM states IDLE, CAPTURE, DRAIN, DONE.
REQ-017 SHALL transition IDLE->CAPTURE and DONE->CAPTURE on arm=1; arm ignored in CAPTURE and DRAIN.
REQ-018 SHALL on arm clear overflow and the last-PC-valid flag; FIFO contents untouched (empty by construction).
REQ-019 SHALL in CAPTURE qualify a writeback when write_reg_addr != 0 and (last-PC-valid=0 or prog_count != last_pc).
REQ-020 SHALL on every CAPTURE cycle load last_pc <= prog_count and set last-PC-valid, qualified or not.
REQ-021 SHALL push {prog_count, write_reg_addr, write_reg_data} for a qualified writeback, visible at outputs the cycle after the capturing edge.
REQ-022 SHALL, when FIFO full and no pop in the same cycle, drop the qualified entry and set overflow; full with simultaneous pop SHALL accept the push.
REQ-023 SHALL in CAPTURE, when prog_count == stop_pc, still evaluate that cycle's capture, then move to DRAIN.
REQ-024 SHALL move DRAIN->DONE on the edge where count is 0, or reaches 0 via a pop.
REQ-025 SHALL assert done only in DONE; no pushes in IDLE, DRAIN, DONE.
REQ-026 SHALL be first-word-fall-through: out_valid = (count != 0); head fields stable while out_valid=1 and out_ready=0.
REQ-027 SHALL pop on out_valid & out_ready in any state; out_ready with empty FIFO has no effect.
REQ-028 SHALL wrap read/write pointers modulo DEPTH; count = pushes minus pops, 0..DEPTH.

Reset
REQ-029 SHALL on rst=0, immediately and regardless of clk: state IDLE, pointers 0, count 0, out_valid 0, overflow 0, done 0, last_pc 0, last-PC-valid 0.
REQ-030 SHALL drive out_pc/out_reg_addr/out_reg_data to 0 while count=0 after reset.
REQ-031 SHALL abort any capture or drain on reset assertion mid-operation, discarding all entries.

Verification
REQ-032 Arm, stop_pc=8; PC 0 addr 2 data 100, PC 4 addr 4 data 535, PC 8 addr 4 data 461, out_ready=1 -> three entries out in order, then done=1, overflow=0.
REQ-033 Same PC held 3 cycles with addr 4 data 535 -> exactly one entry; addr 0 cycles -> no entry.
REQ-034 DEPTH=8, out_ready=0, 10 qualified distinct-PC writebacks -> count=8, overflow=1, first 8 PCs retained in order.
REQ-035 FIFO full, out_ready=1 and qualified writeback same cycle -> count stays 8, overflow stays 0.
REQ-036 rst pulled low mid-CAPTURE with count=3, between clock edges -> count=0, out_valid=0, state IDLE immediately; arm afterwards restarts cleanly.
REQ-037 arm asserted in DRAIN -> ignored; arm in DONE -> CAPTURE, overflow cleared, done=0 next cycle.
